xillybus_mem_arbiter: RTL and testbench
=======================================

XILLYBUS_MEM_ARBITER -- requirements
Module: xillybus_mem_arbiter

Interface
REQ-001 Parameter HOST_QUANTUM, 4, max consecutive host-access cycles while a local request waits.
REQ-002 Parameter LOCAL_QUANTUM, 4, max consecutive local-access cycles while a host device is open.
REQ-003 bus_clk  in  1  sole clock; all logic on rising edge.
REQ-004 srst  in  1  synchronous reset, active-high.
REQ-005 user_mem_8_addr  in  5  host address.
REQ-006 user_w_mem_8_wren  in  1  host write strobe.
REQ-007 user_w_mem_8_data  in  8  host write data.
REQ-008 user_w_mem_8_full  out  1  host write stall, registered.
REQ-009 user_r_mem_8_rden  in  1  host read strobe.
REQ-010 user_r_mem_8_data  out  8  host read data, registered.
REQ-011 user_r_mem_8_empty  out  1  host read stall, registered.
REQ-012 user_r_mem_8_eof  out  1  constant 0.
REQ-013 user_r_mem_8_open, user_w_mem_8_open  in  1 each  host device open flags.
REQ-014 loc_req  in  1  local client request; held until granted.
REQ-015 loc_we  in  1  local write (1) or read (0).
REQ-016 loc_addr  in  5  local address.
REQ-017 loc_wdata  in  8  local write data.
REQ-018 loc_gnt  out  1  local access performed this cycle.
REQ-019 loc_rdata  out  8  local read data.
REQ-020 loc_rvalid  out  1  loc_rdata valid strobe, one cycle.

Function
REQ-021 Block SHALL own one 32x8 RAM shared by host and local client; exactly one owner per cycle.
REQ-022 FSM states: HOST (full=0, empty=0) and LOCAL (full=1, empty=1); full/empty SHALL be registered copies of next state.
REQ-023 Host access: in HOST, wren writes data to addr same edge; rden latches RAM[addr] into user_r_mem_8_data one cycle later.
REQ-024 Simultaneous host wren and rden to same address SHALL return pre-write contents.
REQ-025 host_active = wren or rden in HOST; host_cnt counts consecutive host_active cycles, cleared on entering HOST or any idle HOST cycle.
REQ-026 HOST->LOCAL when loc_req and (not host_active or host_cnt = HOST_QUANTUM-1).
REQ-027 In LOCAL, loc_gnt = loc_req (combinational); granted access executes that edge; local read gives loc_rdata/loc_rvalid one cycle later.
REQ-028 loc_cnt counts granted LOCAL cycles, cleared on LOCAL entry.
REQ-029 LOCAL->HOST when not loc_req, or loc_cnt = LOCAL_QUANTUM-1 and either open flag is 1; with both flags 0 LOCAL SHALL persist while loc_req.
REQ-030 user_r_mem_8_data SHALL change only on host reads; local reads never disturb it.
REQ-031 Host strobes in LOCAL state are protocol violations and SHALL be ignored (no RAM write, no data update).
REQ-032 loc_gnt SHALL be 0 in HOST state.

Reset
REQ-033 srst: state HOST, full=1, empty=1, counters 0, user_r_mem_8_data=0, loc_rdata=0, loc_rvalid=0; full/empty deassert first cycle after srst falls.
REQ-034 RAM contents SHALL NOT be reset; srst mid-LOCAL aborts the burst, pending loc_rvalid suppressed.

Structure
REQ-035 Shared package mem_arb_pkg SHALL hold state enum, ADDR_W=5, DATA_W=8.
REQ-036 RAM SHALL be sub-module demo_ram_32x8 (one write, one read port, common address, registered read).

Verification
REQ-037 Host write 0xA5 to addr 3, read addr 3 -> user_r_mem_8_data=0xA5 one cycle after rden.
REQ-038 Host idle, loc_req write 0x5A addr 7 -> LOCAL next cycle, loc_gnt=1, full/empty=1; host read 7 later returns 0x5A.
REQ-039 Host reads every cycle, loc_req held, HOST_QUANTUM=4 -> LOCAL after 4th host access; full/empty high exactly the LOCAL cycles.
REQ-040 Both opens=1, loc_req held 10 cycles -> LOCAL bursts of 4, at least one HOST cycle between; opens=0 -> one unbroken 10-cycle burst.
REQ-041 Local read addr 3 after host read of 0x11 -> loc_rvalid pulse with data; user_r_mem_8_data stays 0x11.
REQ-042 srst asserted mid-LOCAL -> next cycle loc_gnt=0, loc_rvalid=0, full/empty=1; RAM data intact afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and arbiter state encoding
package mem_arb_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    typedef enum logic {ST_HOST, ST_LOCAL} arb_state_t;
endpackage

// File: rtl/demo_ram_32x8.sv
// demo_ram_32x8: 32x8 RAM, single address, one write port, one read port feeding two registered outputs
module demo_ram_32x8
    import mem_arb_pkg::*;
(
    input  logic              bus_clk,
    input  logic              srst,
    input  logic              we,
    input  logic              re_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    // storage is never reset so contents survive srst
    always_ff @(posedge bus_clk)
        if (we) mem[addr] <= din;
    // each output register captures the pre-write word only on its own read enable
    always_ff @(posedge bus_clk)
        if (srst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (re_a) q_a <= mem[addr];
            if (re_b) q_b <= mem[addr];
        end
endmodule

// File: rtl/xillybus_mem_arbiter.sv
// xillybus_mem_arbiter: shares one 32x8 RAM between a Xillybus host port and a local client
module xillybus_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int HOST_QUANTUM  = 4,
    parameter int LOCAL_QUANTUM = 4
) (
    input  logic              bus_clk,
    input  logic              srst,
    input  logic [ADDR_W-1:0] user_mem_8_addr,
    input  logic              user_w_mem_8_wren,
    input  logic [DATA_W-1:0] user_w_mem_8_data,
    output logic              user_w_mem_8_full,
    input  logic              user_r_mem_8_rden,
    output logic [DATA_W-1:0] user_r_mem_8_data,
    output logic              user_r_mem_8_empty,
    output logic              user_r_mem_8_eof,
    input  logic              user_r_mem_8_open,
    input  logic              user_w_mem_8_open,
    input  logic              loc_req,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic              loc_gnt,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              loc_rvalid
);
    localparam int HCW = $clog2(HOST_QUANTUM + 1);
    localparam int LCW = $clog2(LOCAL_QUANTUM + 1);
    localparam logic [HCW-1:0] HOST_LAST = HCW'(HOST_QUANTUM - 1);
    localparam logic [LCW-1:0] LOC_LAST  = LCW'(LOCAL_QUANTUM - 1);

    arb_state_t        state, next_state;
    logic [HCW-1:0]    host_cnt;
    logic [LCW-1:0]    loc_cnt;
    logic              host_wr, host_rd, host_active, loc_rd, ram_we, any_open;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;

    assign host_wr     = (state == ST_HOST) && user_w_mem_8_wren;
    assign host_rd     = (state == ST_HOST) && user_r_mem_8_rden;
    assign host_active = host_wr || host_rd;
    assign loc_gnt     = (state == ST_LOCAL) && loc_req && !srst;
    assign loc_rd      = loc_gnt && !loc_we;
    assign ram_we      = !srst && (host_wr || (loc_gnt && loc_we));
    assign ram_addr    = (state == ST_LOCAL) ? loc_addr : user_mem_8_addr;
    assign ram_din     = (state == ST_LOCAL) ? loc_wdata : user_w_mem_8_data;
    assign any_open    = user_r_mem_8_open || user_w_mem_8_open;
    assign user_r_mem_8_eof = 1'b0;

    // ownership decision: host yields when idle or its quantum is used up; local yields when done or quantum expires with a host device open
    always_comb begin
        next_state = state;
        if (state == ST_HOST)
            next_state = (loc_req && (!host_active || host_cnt == HOST_LAST)) ? ST_LOCAL : ST_HOST;
        else
            next_state = (!loc_req || (loc_cnt == LOC_LAST && any_open)) ? ST_HOST : ST_LOCAL;
    end

    // state, stall flags and saturating quantum counters; counters restart on every change of owner
    always_ff @(posedge bus_clk)
        if (srst) begin
            state              <= ST_HOST;
            user_w_mem_8_full  <= 1'b1;
            user_r_mem_8_empty <= 1'b1;
            host_cnt           <= '0;
            loc_cnt            <= '0;
            loc_rvalid         <= 1'b0;
        end else begin
            state              <= next_state;
            user_w_mem_8_full  <= (next_state == ST_LOCAL);
            user_r_mem_8_empty <= (next_state == ST_LOCAL);
            host_cnt           <= (host_active && next_state == ST_HOST) ?
                                  ((host_cnt == HOST_LAST) ? host_cnt : host_cnt + HCW'(1)) : '0;
            loc_cnt            <= (state == ST_LOCAL && next_state == ST_LOCAL) ?
                                  ((loc_gnt && loc_cnt != LOC_LAST) ? loc_cnt + LCW'(1) : loc_cnt) : '0;
            loc_rvalid         <= loc_rd;
        end

    demo_ram_32x8 u_ram (
        .bus_clk (bus_clk),
        .srst    (srst),
        .we      (ram_we),
        .re_a    (host_rd && !srst),
        .re_b    (loc_rd),
        .addr    (ram_addr),
        .din     (ram_din),
        .q_a     (user_r_mem_8_data),
        .q_b     (loc_rdata)
    );
endmodule

// File: tb/tb_xillybus_mem_arbiter.sv
// tb_xillybus_mem_arbiter: randomized scoreboard bench for the shared-RAM arbiter
module tb_xillybus_mem_arbiter;
    localparam int HQ = 4;
    localparam int LQ = 4;

    logic       bus_clk = 1'b0;
    logic       srst = 1'b1;
    logic [4:0] user_mem_8_addr = '0;
    logic       user_w_mem_8_wren = 1'b0;
    logic [7:0] user_w_mem_8_data = '0;
    logic       user_w_mem_8_full;
    logic       user_r_mem_8_rden = 1'b0;
    logic [7:0] user_r_mem_8_data;
    logic       user_r_mem_8_empty;
    logic       user_r_mem_8_eof;
    logic       user_r_mem_8_open = 1'b1;
    logic       user_w_mem_8_open = 1'b1;
    logic       loc_req = 1'b0;
    logic       loc_we = 1'b0;
    logic [4:0] loc_addr = '0;
    logic [7:0] loc_wdata = '0;
    logic       loc_gnt;
    logic [7:0] loc_rdata;
    logic       loc_rvalid;

    xillybus_mem_arbiter #(.HOST_QUANTUM(HQ), .LOCAL_QUANTUM(LQ)) dut (
        .bus_clk            (bus_clk),
        .srst               (srst),
        .user_mem_8_addr    (user_mem_8_addr),
        .user_w_mem_8_wren  (user_w_mem_8_wren),
        .user_w_mem_8_data  (user_w_mem_8_data),
        .user_w_mem_8_full  (user_w_mem_8_full),
        .user_r_mem_8_rden  (user_r_mem_8_rden),
        .user_r_mem_8_data  (user_r_mem_8_data),
        .user_r_mem_8_empty (user_r_mem_8_empty),
        .user_r_mem_8_eof   (user_r_mem_8_eof),
        .user_r_mem_8_open  (user_r_mem_8_open),
        .user_w_mem_8_open  (user_w_mem_8_open),
        .loc_req            (loc_req),
        .loc_we             (loc_we),
        .loc_addr           (loc_addr),
        .loc_wdata          (loc_wdata),
        .loc_gnt            (loc_gnt),
        .loc_rdata          (loc_rdata),
        .loc_rvalid         (loc_rvalid)
    );

    always #5 bus_clk = ~bus_clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: who owns the RAM, how long the current owner has held it, and the RAM itself
    bit         m_local = 0;
    bit         m_full = 1;
    int         host_run = 0;
    int         burst = 0;
    logic [7:0] mem [32];
    logic [7:0] host_q [$];
    logic [7:0] loc_q [$];
    logic [7:0] exp_host = '0;
    bit         mon_en = 0;

    // local client: one outstanding operation held until granted
    bit         lc_pend = 0;
    bit         lc_we = 0;
    logic [4:0] lc_addr = '0;
    logic [7:0] lc_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_op(input bit we, input logic [4:0] a, input logic [7:0] d);
        lc_pend = 1;
        lc_we = we;
        lc_addr = a;
        lc_data = d;
    endtask

    // drive one cycle, compare the combinational/stall outputs, then advance the model across the edge
    task automatic cycle(input bit rst, input bit wr, input bit rd, input logic [4:0] a, input logic [7:0] d);
        bit req, gnt, hact;
        @(negedge bus_clk);
        srst = rst;
        user_w_mem_8_wren = wr;
        user_r_mem_8_rden = rd;
        user_mem_8_addr = a;
        user_w_mem_8_data = d;
        loc_req = lc_pend;
        loc_we = lc_we;
        loc_addr = lc_addr;
        loc_wdata = lc_data;
        #1;
        req = lc_pend;
        gnt = m_local && req && !rst;
        check("loc_gnt", 32'(loc_gnt), 32'(gnt));
        check("full", 32'(user_w_mem_8_full), 32'(m_full));
        check("empty", 32'(user_r_mem_8_empty), 32'(m_full));
        if (rst) begin
            host_q.delete();
            loc_q.delete();
            host_q.push_back(8'h00);
            m_local = 0;
            host_run = 0;
            burst = 0;
            m_full = 1;
        end else begin
            hact = !m_local && (wr || rd);
            if (!m_local) begin
                if (rd) host_q.push_back(mem[a]);
                if (wr) mem[a] = d;
            end
            if (gnt) begin
                if (lc_we) mem[lc_addr] = lc_data;
                else loc_q.push_back(mem[lc_addr]);
                lc_pend = 0;
            end
            if (!m_local) begin
                if (req && (!hact || host_run >= HQ - 1)) begin
                    m_local = 1;
                    burst = 0;
                    host_run = 0;
                end else
                    host_run = hact ? host_run + 1 : 0;
            end else if (!req || (burst >= LQ - 1 && (user_r_mem_8_open || user_w_mem_8_open))) begin
                m_local = 0;
                host_run = 0;
            end else if (gnt)
                burst++;
            m_full = m_local;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 5'd0, 8'd0);
    endtask

    // a well-behaved host waits out the stall before strobing
    task automatic host_op(input bit wr, input bit rd, input logic [4:0] a, input logic [7:0] d);
        for (int i = 0; i < 20 && m_full; i++) idle(1);
        cycle(0, wr, rd, a, d);
    endtask

    task automatic burst_test(input bit opens, input int exp_max, input int exp_bursts);
        int left = 10, run = 0, maxrun = 0, bursts = 0;
        user_r_mem_8_open = opens;
        user_w_mem_8_open = opens;
        for (int i = 0; i < 60 && (left > 0 || lc_pend); i++) begin
            if (!lc_pend && left > 0) begin
                new_op(1, 5'($urandom), 8'($urandom));
                left--;
            end
            idle(1);
            if (loc_gnt) begin
                if (run == 0) bursts++;
                run++;
            end else run = 0;
            if (run > maxrun) maxrun = run;
        end
        check("burst_len", 32'(maxrun), 32'(exp_max));
        check("burst_count", 32'(bursts), 32'(exp_bursts));
        idle(3);
    endtask

    task automatic rand_phase(input int n, input bit ro, input bit wo, input int lp);
        bit rst, wr, rd;
        user_r_mem_8_open = ro;
        user_w_mem_8_open = wo;
        for (int i = 0; i < n; i++) begin
            rst = ($urandom % 150) == 0;
            wr = 0;
            rd = 0;
            if (!lc_pend && ($urandom % 100) < lp) new_op(1'($urandom), 5'($urandom), 8'($urandom));
            if (!rst && (!m_full || (m_local && ($urandom % 5) == 0))) begin
                wr = ($urandom % 3) == 0;
                rd = 1'($urandom);
            end
            cycle(rst, wr, rd, 5'($urandom), 8'($urandom));
        end
    endtask

    // monitor: after each edge pop the expected responses and compare what the DUT presents
    always @(posedge bus_clk) begin
        if (mon_en) begin
            #1;
            if (host_q.size() > 0) exp_host = host_q.pop_front();
            check("host_rdata", 32'(user_r_mem_8_data), 32'(exp_host));
            check("eof", 32'(user_r_mem_8_eof), 32'd0);
            if (loc_q.size() > 0) begin
                logic [7:0] e;
                e = loc_q.pop_front();
                check("loc_rvalid", 32'(loc_rvalid), 32'd1);
                check("loc_rdata", 32'(loc_rdata), 32'(e));
            end else
                check("loc_rvalid_idle", 32'(loc_rvalid), 32'd0);
        end
    end

    initial begin
        int hits;
        repeat (2) @(negedge bus_clk);
        check("rst_full", 32'(user_w_mem_8_full), 32'd1);
        check("rst_empty", 32'(user_r_mem_8_empty), 32'd1);
        check("rst_rdata", 32'(user_r_mem_8_data), 32'd0);
        check("rst_loc_rdata", 32'(loc_rdata), 32'd0);
        check("rst_rvalid", 32'(loc_rvalid), 32'd0);
        check("rst_gnt", 32'(loc_gnt), 32'd0);
        mon_en = 1;
        idle(1);
        for (int a = 0; a < 32; a++) host_op(1, 0, 5'(a), 8'($urandom));

        host_op(1, 0, 5'd3, 8'hA5);
        host_op(0, 1, 5'd3, 8'h00);
        host_op(1, 1, 5'd3, 8'h3C);
        idle(2);

        new_op(1, 5'd7, 8'h5A);
        idle(4);
        host_op(0, 1, 5'd7, 8'h00);

        host_op(1, 0, 5'd3, 8'h11);
        host_op(0, 1, 5'd3, 8'h00);
        new_op(0, 5'd3, 8'h00);
        idle(5);

        idle(2);
        new_op(0, 5'd9, 8'h00);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 5'(i), 8'h00);
            hits++;
            @(posedge bus_clk);
            #1;
            if (user_w_mem_8_full) break;
        end
        check("host_quantum", 32'(hits), 32'(HQ));
        idle(4);

        burst_test(1, LQ, 3);
        burst_test(0, 10, 1);

        user_r_mem_8_open = 0;
        user_w_mem_8_open = 0;
        new_op(1, 5'd20, 8'hC3);
        for (int i = 0; i < 10 && !m_local; i++) idle(1);
        for (int i = 0; i < 2; i++) begin
            if (!lc_pend) new_op(0, 5'(i), 8'h00);
            idle(1);
        end
        if (!lc_pend) new_op(0, 5'd20, 8'h00);
        cycle(1, 0, 0, 5'd0, 8'd0);
        @(posedge bus_clk);
        #2;
        check("srst_full", 32'(user_w_mem_8_full), 32'd1);
        check("srst_gnt", 32'(loc_gnt), 32'd0);
        check("srst_rvalid", 32'(loc_rvalid), 32'd0);
        idle(6);
        for (int a = 0; a < 32; a++) host_op(0, 1, 5'(a), 8'h00);

        rand_phase(500, 1, 1, 30);
        rand_phase(500, 0, 0, 50);
        rand_phase(500, 1, 0, 70);
        rand_phase(300, 0, 1, 10);
        idle(6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
